aes_iter_cipher: RTL and testbench

Iterative AES forward cipher (FIPS-197 encryption) for AES-128/192/256. It is the encrypt-side counterpart of the iterative inverse cipher and consumes the same pre-expanded key schedule layout, so one key expander feeds both directions. The block executes one round per clock behind a start/busy/done handshake and holds the ciphertext in a register until the next block completes.

---
 rtl/aes_pkg.sv | 57 +++++
 rtl/aes_enc_round.sv | 44 ++++
 rtl/aes_iter_cipher.sv | 112 +++++++++++
 tb/tb_aes_iter_cipher.sv | 269 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/aes_pkg.sv
// Shared AES definitions: S-box, GF(2^8) helpers, FSM states and block type.
// Used by both the forward and inverse iterative ciphers.
package aes_pkg;

  typedef logic [0:127] block_t;

  typedef enum logic [1:0] {
    IDLE,
    ROUND,
    FINAL
  } state_e;

  // Byte b of the table is the substitution of value b; bit 0 is the MSB.
  localparam logic [0:2047] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  function automatic logic [7:0] sbox(input logic [7:0] b);
    return SBOX[{b, 3'b000} +: 8];
  endfunction

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] b, input logic [7:0] m);
    logic [7:0] acc;
    logic [7:0] a;
    acc = 8'h00;
    a   = b;
    for (int i = 0; i < 8; i++) begin
      if (m[i]) acc = acc ^ a;
      a = xtime(a);
    end
    return acc;
  endfunction

  function automatic int nr_from_nk(input int nk);
    return nk + 6;
  endfunction

endpackage

// File: rtl/aes_enc_round.sv
// One combinational AES encryption round: SubBytes, ShiftRows, MixColumns
// (skipped when final_round_i is set) and AddRoundKey.
module aes_enc_round
  import aes_pkg::*;
(
  input  logic [0:127] state_i,
  input  logic [0:127] round_key_i,
  input  logic         final_round_i,
  output logic [0:127] state_o
);

  block_t sb;
  block_t sr;
  block_t mc;

  function automatic logic [0:31] mix_col(input logic [0:31] col);
    logic [7:0] a0, a1, a2, a3;
    a0 = col[0:7];
    a1 = col[8:15];
    a2 = col[16:23];
    a3 = col[24:31];
    return {gmul(a0, 8'h02) ^ gmul(a1, 8'h03) ^ a2 ^ a3,
            a0 ^ gmul(a1, 8'h02) ^ gmul(a2, 8'h03) ^ a3,
            a0 ^ a1 ^ gmul(a2, 8'h02) ^ gmul(a3, 8'h03),
            gmul(a0, 8'h03) ^ a1 ^ a2 ^ gmul(a3, 8'h02)};
  endfunction

  always_comb begin
    sb = '0;
    sr = '0;
    mc = '0;
    for (int i = 0; i < 16; i++) sb[8*i +: 8] = sbox(state_i[8*i +: 8]);
    // Row r of column c takes the byte from column (c+r) mod 4.
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        sr[8*(4*c + r) +: 8] = sb[8*(4*((c + r) % 4) + r) +: 8];
      end
    end
    for (int c = 0; c < 4; c++) mc[32*c +: 32] = mix_col(sr[32*c +: 32]);
  end

  assign state_o = (final_round_i ? sr : mc) ^ round_key_i;

endmodule

// File: rtl/aes_iter_cipher.sv
// Iterative AES-128/192/256 encryption, one round per clock, start/busy/done handshake.
// Define AES_CIPHER_KEY_LATCH_EN to register the key schedule on the accepting edge.
module aes_iter_cipher
  import aes_pkg::*;
#(
  parameter int Nk = 4,
  parameter int Nr = nr_from_nk(Nk)
) (
  input  logic                     clks,
  input  logic                     reset,
  input  logic                     start,
  input  logic [0:127]             plain_text,
  input  logic [0:128*(Nr+1)-1]    keys,
  output logic                     busy,
  output logic                     done,
  output logic [0:127]             cipher_text
);

  localparam int         KW        = 128 * (Nr + 1);
  localparam logic [3:0] LAST_RND  = 4'(Nr - 1);

  state_e       fsm_q, fsm_d;
  logic [3:0]   round_q, round_d;
  block_t       state_q, state_d;
  block_t       ct_q, ct_d;
  logic         busy_q, busy_d;
  logic         done_q, done_d;

  logic [0:KW-1] key_src;
  block_t        round_key;
  block_t        round_out;

`ifdef AES_CIPHER_KEY_LATCH_EN
  logic [0:KW-1] keys_q, keys_d;

  assign keys_d  = (fsm_q == IDLE && start) ? keys : keys_q;
  assign key_src = keys_q;

  always_ff @(posedge clks) begin
    if (reset) keys_q <= '0;
    else       keys_q <= keys_d;
  end
`else
  assign key_src = keys;
`endif

  // round_q equals Nr while in FINAL, so one index serves both round kinds.
  assign round_key = key_src[{round_q, 7'd0} +: 128];

  aes_enc_round u_round (
    .state_i       (state_q),
    .round_key_i   (round_key),
    .final_round_i (fsm_q == FINAL),
    .state_o       (round_out)
  );

  always_comb begin
    fsm_d   = fsm_q;
    round_d = round_q;
    state_d = state_q;
    ct_d    = ct_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    case (fsm_q)
      IDLE: begin
        if (start) begin
          // Key 0 comes straight from the port: the latch (if any) fills on this edge.
          state_d = plain_text ^ keys[0:127];
          round_d = 4'd1;
          busy_d  = 1'b1;
          fsm_d   = ROUND;
        end
      end
      ROUND: begin
        state_d = round_out;
        round_d = round_q + 4'd1;
        if (round_q == LAST_RND) fsm_d = FINAL;
      end
      FINAL: begin
        ct_d    = round_out;
        done_d  = 1'b1;
        busy_d  = 1'b0;
        round_d = 4'd0;
        fsm_d   = IDLE;
      end
      default: fsm_d = IDLE;
    endcase
  end

  always_ff @(posedge clks) begin
    if (reset) begin
      fsm_q   <= IDLE;
      round_q <= 4'd0;
      state_q <= '0;
      ct_q    <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      fsm_q   <= fsm_d;
      round_q <= round_d;
      state_q <= state_d;
      ct_q    <= ct_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign busy        = busy_q;
  assign done        = done_q;
  assign cipher_text = ct_q;

endmodule

// File: tb/tb_aes_iter_cipher.sv
// Scoreboard bench for aes_iter_cipher: FIPS-197 vectors at Nk=4/6/8, back-to-back,
// busy-ignored starts, mid-operation reset and key-change-after-start.
module tb_aes_iter_cipher;

  typedef struct {
    logic [0:127] ct;
    int           due;
  } exp_t;

  localparam logic [0:127] K_FIPS   = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [0:127] PT_FIPS  = 128'h3243f6a8885a308d313198a2e0370734;
  localparam logic [0:127] CT_FIPS  = 128'h3925841d02dc09fbdc118597196a0b32;
  localparam logic [0:255] K_APPC   = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
  localparam logic [0:127] PT_APPC  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [0:127] CT_128   = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [0:127] CT_192   = 128'hdda97ca4864cdfe06eaf70a0ec0d7191;
  localparam logic [0:127] CT_256   = 128'h8ea2b7ca516745bfeafc49904b496089;
  localparam logic [0:127] CT_ZERO  = 128'h66e94bd4ef8a2c3b884cfa59ca342b2e;

  logic [0:2047] tb_sbox = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
  };

  logic clks;
  logic reset;
  int   cyc = 0;
  int   errors = 0;
  int   checks = 0;

  logic            start4, start6, start8;
  logic [0:127]    pt4, pt6, pt8;
  logic [0:1407]   keys4;
  logic [0:1663]   keys6;
  logic [0:1919]   keys8;
  logic            busy4, busy6, busy8;
  logic            done4, done6, done8;
  logic [0:127]    ct4, ct6, ct8;

  exp_t q4[$];
  exp_t q6[$];
  exp_t q8[$];
  exp_t m4, m6, m8;

  aes_iter_cipher #(.Nk(4)) dut4 (
    .clks(clks), .reset(reset), .start(start4), .plain_text(pt4), .keys(keys4),
    .busy(busy4), .done(done4), .cipher_text(ct4));
  aes_iter_cipher #(.Nk(6)) dut6 (
    .clks(clks), .reset(reset), .start(start6), .plain_text(pt6), .keys(keys6),
    .busy(busy6), .done(done6), .cipher_text(ct6));
  aes_iter_cipher #(.Nk(8)) dut8 (
    .clks(clks), .reset(reset), .start(start8), .plain_text(pt8), .keys(keys8),
    .busy(busy8), .done(done8), .cipher_text(ct8));

  initial clks = 1'b0;
  always #5 clks = ~clks;
  always @(posedge clks) cyc <= cyc + 1;

  function automatic logic [7:0] tsb(input logic [7:0] b);
    return tb_sbox[{b, 3'b000} +: 8];
  endfunction

  function automatic logic [7:0] tx(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [31:0] subw(input logic [31:0] w);
    return {tsb(w[31:24]), tsb(w[23:16]), tsb(w[15:8]), tsb(w[7:0])};
  endfunction

  // Standard key expansion; round key r lands at bits [128r +: 128].
  function automatic logic [0:1919] expand(input logic [0:255] key, input int nk);
    logic [31:0]   w [60];
    logic [31:0]   t;
    logic [7:0]    rc;
    logic [0:1919] res;
    int            nw;
    nw  = 4 * (nk + 7);
    res = '0;
    rc  = 8'h01;
    for (int i = 0; i < 60; i++) w[i] = '0;
    for (int i = 0; i < nk; i++) w[i] = key[32*i +: 32];
    for (int i = nk; i < nw; i++) begin
      t = w[i-1];
      if (i % nk == 0) begin
        t  = subw({t[23:0], t[31:24]}) ^ {rc, 24'h0};
        rc = tx(rc);
      end else if (nk > 6 && i % nk == 4) begin
        t = subw(t);
      end
      w[i] = w[i-nk] ^ t;
    end
    for (int i = 0; i < nw; i++) res[32*i +: 32] = w[i];
    return res;
  endfunction

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h, required %0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  task automatic load4(input logic [0:255] k);
    logic [0:1919] tmp;
    tmp   = expand(k, 4);
    keys4 = tmp[0:1407];
  endtask

  task automatic push4(input logic [0:127] ct);
    exp_t e;
    e.ct  = ct;
    e.due = cyc + 10;
    q4.push_back(e);
  endtask

  // Drive at a negedge; the following posedge accepts; returns at the next negedge.
  task automatic pulse4(input logic [0:127] pt, input logic [0:127] ct, input bit push);
    pt4    = pt;
    start4 = 1'b1;
    @(negedge clks);
    start4 = 1'b0;
    if (push) push4(ct);
  endtask

  always @(negedge clks) begin
    if (done4) begin
      if (q4.size() == 0) begin
        checks++; errors++;
        $display("FAIL dut4_unexpected_done: got done=1 at cycle %0d, required no done", cyc);
      end else begin
        m4 = q4.pop_front();
        chk("dut4_cipher_text", ct4, m4.ct);
        chk("dut4_done_cycle", cyc, m4.due);
      end
    end
  end

  always @(negedge clks) begin
    if (done6) begin
      if (q6.size() == 0) begin
        checks++; errors++;
        $display("FAIL dut6_unexpected_done: got done=1 at cycle %0d, required no done", cyc);
      end else begin
        m6 = q6.pop_front();
        chk("dut6_cipher_text", ct6, m6.ct);
        chk("dut6_done_cycle", cyc, m6.due);
      end
    end
  end

  always @(negedge clks) begin
    if (done8) begin
      if (q8.size() == 0) begin
        checks++; errors++;
        $display("FAIL dut8_unexpected_done: got done=1 at cycle %0d, required no done", cyc);
      end else begin
        m8 = q8.pop_front();
        chk("dut8_cipher_text", ct8, m8.ct);
        chk("dut8_done_cycle", cyc, m8.due);
      end
    end
  end

  initial begin
    #50000;
    $display("FAIL watchdog: simulation time limit reached, errors=%0d", errors);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [0:1919] tmp;
    exp_t          e;
    reset  = 1'b1;
    start4 = 1'b0; start6 = 1'b0; start8 = 1'b0;
    pt4 = '0; pt6 = '0; pt8 = '0;
    keys4 = '0; keys6 = '0; keys8 = '0;
    repeat (3) @(negedge clks);
    chk("reset_busy", busy4, 1'b0);
    chk("reset_done", done4, 1'b0);
    chk("reset_cipher_text", ct4, 128'h0);
    chk("reset_busy_nk8", busy8, 1'b0);
    reset = 1'b0;
    @(negedge clks);

    // FIPS-197 Appendix B vector
    load4({K_FIPS, 128'h0});
    pulse4(PT_FIPS, CT_FIPS, 1'b1);
    chk("busy_after_accept", busy4, 1'b1);
    repeat (12) @(negedge clks);

    // Appendix C vectors on all three key lengths at once
    load4(K_APPC);
    tmp   = expand(K_APPC, 6);
    keys6 = tmp[0:1663];
    keys8 = expand(K_APPC, 8);
    pt6 = PT_APPC; pt8 = PT_APPC;
    start6 = 1'b1; start8 = 1'b1;
    pulse4(PT_APPC, CT_128, 1'b1);
    start6 = 1'b0; start8 = 1'b0;
    e.ct = CT_192; e.due = cyc + 12; q6.push_back(e);
    e.ct = CT_256; e.due = cyc + 14; q8.push_back(e);
    repeat (16) @(negedge clks);

    // start held high: three blocks spaced Nr+1 cycles, inputs swapped in the done cycle
    load4({K_FIPS, 128'h0});
    pt4    = PT_FIPS;
    start4 = 1'b1;
    @(negedge clks);
    push4(CT_FIPS);
    repeat (10) @(negedge clks);
    load4(K_APPC);
    pt4 = PT_APPC;
    @(negedge clks);
    push4(CT_128);
    repeat (10) @(negedge clks);
    load4(256'h0);
    pt4 = 128'h0;
    @(negedge clks);
    start4 = 1'b0;
    push4(CT_ZERO);
    repeat (12) @(negedge clks);

    // starts while busy must be ignored
    load4({K_FIPS, 128'h0});
    pulse4(PT_FIPS, CT_FIPS, 1'b1);
    chk("busy_mid_block", busy4, 1'b1);
    pulse4(128'h0, 128'h0, 1'b0);
    repeat (3) @(negedge clks);
    pulse4(PT_APPC, 128'h0, 1'b0);
    repeat (10) @(negedge clks);

    // reset while round counter is at 5
    pulse4(PT_APPC, 128'h0, 1'b0);
    repeat (4) @(negedge clks);
    chk("busy_before_abort", busy4, 1'b1);
    reset = 1'b1;
    @(negedge clks);
    reset = 1'b0;
    chk("abort_busy", busy4, 1'b0);
    chk("abort_done", done4, 1'b0);
    chk("abort_cipher_text", ct4, 128'h0);
    pulse4(PT_FIPS, CT_FIPS, 1'b1);
    repeat (12) @(negedge clks);

    // keys cleared one cycle after start (only allowed with the key latch)
    pulse4(PT_FIPS, CT_FIPS, 1'b1);
`ifdef AES_CIPHER_KEY_LATCH_EN
    keys4 = '0;
`endif

    for (int i = 0; i < 40 && (q4.size() + q6.size() + q8.size()) != 0; i++) @(negedge clks);
    chk("dut4_pending_blocks", q4.size(), 0);
    chk("dut6_pending_blocks", q6.size(), 0);
    chk("dut8_pending_blocks", q8.size(), 0);
    repeat (3) @(negedge clks);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
